// File: rtl/btn_reset_pkg.sv
// Shared types and cycle-count helpers for the button reset controller.
// Long-press support is enabled with BTN_RESET_CTRL_LONG_PRESS_EN.
package btn_reset_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      LONG = 2'd2
   } state_t;

   function automatic int db_cycles(input int hz, input int us);
      return hz / 1000000 * us;
   endfunction

   function automatic int long_cycles(input int hz, input int ms);
      return hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus counting debouncer for an active-low button.
// btn_level toggles after sync_p disagrees with it for DB_CYCLES cycles.
module btn_debounce #(
   parameter int DB_CYCLES = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic btn_level
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

   logic          s1;
   logic          sync_p;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         sync_p    <= 1'b0;
         cnt       <= '0;
         btn_level <= 1'b0;
      end else begin
         s1     <= ~btn_n;
         sync_p <= s1;
         if (sync_p == btn_level) begin
            cnt <= '0;
         end else if (cnt == CMAX) begin
            btn_level <= ~btn_level;
            cnt       <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_reset_ctrl.sv
// Button press classifier: short presses counted, long press requests reset.
// Long-press path present only with BTN_RESET_CTRL_LONG_PRESS_EN defined.
module btn_reset_ctrl
   import btn_reset_pkg::*;
#(
   parameter int CLOCK_HZ    = 48000000,
   parameter int DEBOUNCE_US = 10000,
   parameter int LONG_MS     = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n,
   output logic       btn_level,
   output logic       short_press,
   output logic       reset_req,
   output logic [7:0] press_count
);

   localparam int DB_CYCLES = db_cycles(CLOCK_HZ, DEBOUNCE_US);

   state_t state;
   state_t state_nxt;

   btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_n    (btn_n),
      .btn_level(btn_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

`ifdef BTN_RESET_CTRL_LONG_PRESS_EN

   localparam int LONG_CYCLES = long_cycles(CLOCK_HZ, LONG_MS);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [HW-1:0] HMAX = HW'(LONG_CYCLES - 1);

   logic [HW-1:0] hcnt;
   logic          at_long;

   assign at_long = (hcnt == HMAX);

   // Counter sits at zero while idle and freezes once the threshold is hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
      end else if (state == IDLE) begin
         hcnt <= '0;
      end else if (state == HOLD && !at_long) begin
         hcnt <= hcnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (btn_level) state_nxt = HOLD;
         HOLD: begin
            if (at_long)        state_nxt = btn_level ? LONG : IDLE;
            else if (!btn_level) state_nxt = IDLE;
         end
         LONG: if (!btn_level) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Threshold wins over a simultaneous release.
   always_comb begin
      short_press = 1'b0;
      reset_req   = 1'b0;
      if (state == HOLD) begin
         reset_req   = at_long;
         short_press = !at_long && !btn_level;
      end
   end

`else

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (btn_level) state_nxt = HOLD;
         HOLD: if (!btn_level) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      short_press = (state == HOLD) && !btn_level;
      reset_req   = 1'b0;
   end

`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           press_count <= 8'd0;
      else if (short_press) press_count <= press_count + 8'd1;
   end

endmodule

// File: tb/tb_btn_reset_ctrl.sv
// Self-checking bench for btn_reset_ctrl with DB_CYCLES=10, LONG_CYCLES=1000.
// Expected pulses are queued at stimulus time and matched as they appear.
module tb_btn_reset_ctrl;

   localparam int DB = 10;
   localparam int LC = 1000;
`ifdef BTN_RESET_CTRL_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_n = 1'b1;
   logic       btn_level;
   logic       short_press;
   logic       reset_req;
   logic [7:0] press_count;

   btn_reset_ctrl #(
      .CLOCK_HZ   (1000000),
      .DEBOUNCE_US(10),
      .LONG_MS    (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_n      (btn_n),
      .btn_level  (btn_level),
      .short_press(short_press),
      .reset_req  (reset_req),
      .press_count(press_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int kind;
      int at;
   } ev_t;

   typedef struct {
      int low;
      int kind;
   } vec_t;

   ev_t        expq[$];
   vec_t       vecs[7];
   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_cnt = 8'd0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Advance to the next falling edge and score any pulse seen there.
   task automatic tick();
      ev_t e;
      int  kind;
      @(negedge clk);
      if (short_press || reset_req) begin
         check("pulse_exclusive", int'(short_press && reset_req), 0);
         kind = short_press ? 1 : 2;
         if (expq.size() == 0) begin
            check("unexpected_pulse_kind", kind, 0);
         end else begin
            e = expq.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.at);
         end
      end
   endtask

   task automatic push(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      expq.push_back(e);
   endtask

   task automatic press(input int low, input int kind);
      int n;
      n = cyc;
      btn_n = 1'b0;
      if (kind == 1) begin
         push(1, n + low + 2 + DB);
         exp_cnt = exp_cnt + 8'd1;
      end else if (kind == 2) begin
         push(2, n + 2 + DB + LC);
      end
      for (int k = 1; k <= low + 40; k++) begin
         tick();
         if (k == low) btn_n = 1'b1;
         if (k == 1 + DB) check("level_before", int'(btn_level), 0);
         if (k == 2 + DB) check("level_after", int'(btn_level),
                                int'(low >= DB));
      end
      check("press_count", int'(press_count), int'(exp_cnt));
   endtask

   initial begin
      int m;
      int n;
      int lk;

      lk = LONG_EN ? 2 : 1;
      vecs[0] = '{low: 50,   kind: 1};
      vecs[1] = '{low: 5,    kind: 0};
      vecs[2] = '{low: 9,    kind: 0};
      vecs[3] = '{low: 10,   kind: 1};
      vecs[4] = '{low: 999,  kind: 1};
      vecs[5] = '{low: 1000, kind: lk};
      vecs[6] = '{low: 1500, kind: lk};

      repeat (3) tick();
      check("rst_level", int'(btn_level), 0);
      check("rst_short", int'(short_press), 0);
      check("rst_reset_req", int'(reset_req), 0);
      check("rst_count", int'(press_count), 0);
      rst_n = 1'b1;
      repeat (5) tick();

      foreach (vecs[i]) press(vecs[i].low, vecs[i].kind);

      for (int g = 0; g < 20; g++) press(5, 0);

      n = int'(exp_cnt);
      for (int p = 0; p < 256; p++) press(12, 1);
      check("wrap_count", int'(press_count), n);

      // Reset in the middle of a hold, button kept pressed.
      n = cyc;
      btn_n = 1'b0;
      for (int k = 1; k <= 513; k++) tick();
      rst_n = 1'b0;
      #1;
      exp_cnt = 8'd0;
      check("midrst_level", int'(btn_level), 0);
      check("midrst_short", int'(short_press), 0);
      check("midrst_reset_req", int'(reset_req), 0);
      check("midrst_count", int'(press_count), 0);
      repeat (3) tick();
      rst_n = 1'b1;
      m = cyc;
      if (LONG_EN) begin
         push(2, m + 2 + DB + LC);
      end else begin
         push(1, m + 1100 + 2 + DB);
         exp_cnt = 8'd1;
      end
      for (int k = 1; k <= 1140; k++) begin
         tick();
         if (k == 1100) btn_n = 1'b1;
         if (k == 1 + DB) check("rel_level_before", int'(btn_level), 0);
         if (k == 2 + DB) check("rel_level_after", int'(btn_level), 1);
      end
      check("rel_count", int'(press_count), int'(exp_cnt));

      check("missing_pulses", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btn_reset_ctrl.md
BTN_RESET_CTRL -- requirements
Module: btn_reset_ctrl

Interface
REQ-001 Parameter CLOCK_HZ, default 48000000, input clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_US, default 10000, debounce window in microseconds; DB_CYCLES = CLOCK_HZ/1000000*DEBOUNCE_US, SHALL be >= 1.
REQ-003 Parameter LONG_MS, default 2000, long-press threshold in ms; LONG_CYCLES = CLOCK_HZ/1000*LONG_MS, SHALL be > DB_CYCLES.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 btn_n  in  1  raw asynchronous user button, low = pressed.
REQ-007 btn_level  out  1  debounced button state, 1 = pressed.
REQ-008 short_press  out  1  one-cycle pulse on release of a press shorter than LONG_CYCLES.
REQ-009 reset_req  out  1  one-cycle pulse when a press reaches LONG_CYCLES; feeds reset_timer trigger.
REQ-010 press_count  out  8  count of short presses, modulo 256.

Function
REQ-011 btn_n SHALL pass through a 2-flop synchronizer before any other use; synchronized value sync_p = ~btn_n delayed 2 cycles.
REQ-012 Debounce counter SHALL clear on any cycle where sync_p equals btn_level, and increment while they differ.
REQ-013 btn_level SHALL toggle on the cycle the debounce counter reaches DB_CYCLES-1 with mismatch still present; counter clears same cycle.
REQ-014 Latency from a clean btn_n edge to btn_level change SHALL be exactly 2 + DB_CYCLES cycles.
REQ-015 Any mismatch shorter than DB_CYCLES cycles SHALL leave btn_level unchanged.
REQ-016 FSM states: IDLE (released), HOLD (pressed, timing), LONG (long press fired, awaiting release).
REQ-017 IDLE -> HOLD on btn_level rising; hold counter loads 0.
REQ-018 In HOLD hold counter SHALL increment each cycle; on reaching LONG_CYCLES-1 reset_req pulses one cycle and FSM -> LONG.
REQ-019 HOLD with btn_level falling -> IDLE, short_press pulses one cycle, press_count increments.
REQ-020 LONG with btn_level falling -> IDLE with no short_press and no press_count change.
REQ-021 Release and threshold in the same cycle SHALL be resolved as long press: reset_req pulses, FSM -> IDLE, no short_press.
REQ-022 press_count SHALL wrap 255 -> 0 without flag.
REQ-023 Hold counter width SHALL be $clog2(LONG_CYCLES); it SHALL never wrap (stops in LONG).
REQ-024 short_press and reset_req SHALL never be high in the same cycle.

Reset
REQ-025 rst_n low SHALL asynchronously force: synchronizer flops 0, debounce counter 0, btn_level 0, FSM IDLE, hold counter 0, short_press 0, reset_req 0, press_count 0.
REQ-026 Reset deassertion mid-press SHALL treat the button as newly pressed; full debounce and full LONG_CYCLES required again.
REQ-027 Reset asserted during HOLD or LONG SHALL emit no pulse.

Configuration
REQ-028 Macro BTN_RESET_CTRL_LONG_PRESS_EN defined: LONG state, hold counter and reset_req behave as above.
REQ-029 Macro undefined: LONG state and hold counter omitted, reset_req tied 0, every debounced release yields short_press and press_count increment regardless of duration.

Structure
REQ-030 Shared package btn_reset_pkg SHALL hold FSM state typedef (IDLE, HOLD, LONG) and the cycle-count helper constants.
REQ-031 Debounce logic SHALL be a sub-module btn_debounce (synchronizer + debounce counter, output btn_level); FSM and counters live in btn_reset_ctrl.

Verification (CLOCK_HZ=1000000, DEBOUNCE_US=10 -> DB_CYCLES=10, LONG_MS=1 -> LONG_CYCLES=1000)
REQ-032 btn_n low 50 cycles then high -> btn_level high at cycle 12, short_press pulse at release+12, press_count=1, reset_req never high.
REQ-033 btn_n 5-cycle low glitches repeated 20 times -> btn_level stays 0, no pulses.
REQ-034 btn_n low 1500 cycles -> reset_req single pulse 1000 cycles after btn_level rise; release gives no short_press, press_count unchanged.
REQ-035 256 short presses -> press_count returns to 0, 256 short_press pulses.
REQ-036 rst_n low for 3 cycles at hold count 500, btn_n held low -> all outputs 0, reset_req fires 2+10+1000 cycles after rst_n release.
REQ-037 Macro undefined, btn_n low 1500 cycles -> reset_req 0, one short_press on release, press_count=1.
